// File: rtl/hazard_controller.sv
// Hazard and execute-stage sequencing controller for the 5-stage RISC-V core:
// operand forwarding, load-use/branch stall-flush, and a multi-cycle op FSM.
module hazard_controller #(
  parameter int unsigned MC_LATENCY = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             McOpE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             McStart,
  output logic             McDone,
  output logic             McBusy,
  output logic [CNT_W-1:0] StallCnt
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [3:0] CNT_INIT = 4'(MC_LATENCY - 1);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               mc_stall;
  logic               lw_stall;

  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) ForwardAE = 2'b01;

    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) ForwardBE = 2'b01;
  end

  assign lw_stall = (ResultSrcE == 2'b01) && (RdE != '0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  // cnt counts down the remaining BUSY cycles; the cnt == 1 cycle releases E
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mc_stall = 1'b0;
    McStart  = 1'b0;
    McDone   = 1'b0;
    case (state_q)
      IDLE: begin
        if (McOpE) begin
          McStart  = 1'b1;
          mc_stall = 1'b1;
          cnt_d    = CNT_INIT;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd1) begin
          mc_stall = 1'b1;
          cnt_d    = cnt_q - 4'd1;
        end else begin
          McDone  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A held multi-cycle op masks load-use and branch so the held D/E is not flushed
  always_comb begin
    McBusy      = (state_q == BUSY);
    StallF      = mc_stall | lw_stall;
    StallD      = mc_stall | lw_stall;
    StallE      = mc_stall;
    FlushM      = mc_stall;
    FlushD      = ~mc_stall & PCSrcE;
    FlushE      = ~mc_stall & (lw_stall | PCSrcE);
    StallCnt    = stall_cnt_q;
    stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, StallF};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios plus random traffic, checked
// against an elapsed-cycle reference model for MC_LATENCY = 4 and 2.
module tb_hazard_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, PCSrcE, McOpE;
  logic [1:0] ResultSrcE;

  logic [1:0][1:0]  fa, fb;
  logic [1:0]       sf, sd, se, fd, fe, fm, mst, mdn, mbz;
  logic [1:0][31:0] scnt;

  hazard_controller #(.MC_LATENCY(4), .CNT_W(32)) u_l4 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .McOpE(McOpE),
    .ForwardAE(fa[0]), .ForwardBE(fb[0]), .StallF(sf[0]), .StallD(sd[0]),
    .StallE(se[0]), .FlushD(fd[0]), .FlushE(fe[0]), .FlushM(fm[0]),
    .McStart(mst[0]), .McDone(mdn[0]), .McBusy(mbz[0]), .StallCnt(scnt[0]));

  hazard_controller #(.MC_LATENCY(2), .CNT_W(32)) u_l2 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .McOpE(McOpE),
    .ForwardAE(fa[1]), .ForwardBE(fb[1]), .StallF(sf[1]), .StallD(sd[1]),
    .StallE(se[1]), .FlushD(fd[1]), .FlushE(fe[1]), .FlushM(fm[1]),
    .McStart(mst[1]), .McDone(mdn[1]), .McBusy(mbz[1]), .StallCnt(scnt[1]));

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  // Model: age = cycles elapsed since a multi-cycle op was accepted (0 = none)
  int          lat [2] = '{4, 2};
  int          age [2] = '{0, 0};
  logic [31:0] mcnt[2] = '{32'd0, 32'd0};
  logic        e_sf[2], e_start[2], e_done[2], e_busy[2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clr();
    rst = 1'b0; Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0;
    RdW = '0; RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE = '0; PCSrcE = 1'b0;
    McOpE = 1'b0;
  endtask

  task automatic sample();
    logic lw, mcs;
    logic [8:0] ctl_exp, ctl_obs;
    @(negedge clk);
    lw = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
    for (int k = 0; k < 2; k++) begin
      e_busy[k]  = (age[k] > 0);
      e_start[k] = (age[k] == 0) && McOpE;
      e_done[k]  = (age[k] == lat[k] - 1);
      mcs        = e_start[k] || (e_busy[k] && !e_done[k]);
      e_sf[k]    = mcs || lw;
      ctl_exp = {e_sf[k], e_sf[k], mcs, !mcs && PCSrcE, !mcs && (lw || PCSrcE), mcs,
                 e_start[k], e_done[k], e_busy[k]};
      ctl_obs = {sf[k], sd[k], se[k], fd[k], fe[k], fm[k], mst[k], mdn[k], mbz[k]};
      check($sformatf("ctl_L%0d", lat[k]), ctl_obs, ctl_exp);
      check($sformatf("fwd_L%0d", lat[k]), {fa[k], fb[k]}, {fwd_ref(Rs1E), fwd_ref(Rs2E)});
      check($sformatf("cnt_L%0d", lat[k]), scnt[k], mcnt[k]);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        age[k] = 0; mcnt[k] = '0;
      end else begin
        if (e_sf[k]) mcnt[k] = mcnt[k] + 32'd1;
        if (e_start[k])     age[k] = 1;
        else if (e_done[k]) age[k] = 0;
        else if (e_busy[k]) age[k] = age[k] + 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    clr(); rst = 1'b1; sample(); advance(); rst = 1'b0;
  endtask

  initial begin
    clr();
    #1;
    do_reset();

    sample();
    check("rst_ctl", {sf[0], sd[0], se[0], fd[0], fe[0], fm[0], mst[0], mdn[0], mbz[0], fa[0], fb[0]}, 0);
    check("rst_cnt", scnt[0], 0);
    advance();

    RdM = 5; RdW = 5; Rs1E = 5; RegWriteM = 1; RegWriteW = 1;
    sample(); check("fwd_m", fa[0], 2'b10); advance();
    RegWriteM = 0;
    sample(); check("fwd_w", fa[0], 2'b01); advance();
    Rs1E = 0; RdM = 0; RdW = 0; RegWriteM = 1;
    sample(); check("fwd_x0", fa[0], 2'b00); advance();

    clr(); ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    sample(); check("lw_ctl", {sf[0], sd[0], fe[0], se[0]}, 4'b1110); advance();
    clr();
    sample(); check("lw_cnt", scnt[0], 1); advance();
    ResultSrcE = 2'b01; RdE = 0; Rs2D = 0;
    sample(); check("lw_rd0", {sf[0], fe[0]}, 2'b00); advance();

    clr(); PCSrcE = 1;
    sample(); check("br_ctl", {fd[0], fe[0], sf[0], se[0]}, 4'b1100); advance();
    PCSrcE = 0;
    sample(); check("br_off", {fd[0], fe[0]}, 2'b00); advance();

    do_reset();
    McOpE = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1 || i == 2) begin
        PCSrcE = 1; ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
      end else begin
        PCSrcE = 0; ResultSrcE = 2'b00; RdE = 0; Rs1D = 0;
      end
      sample();
      check("mc_start", mst[0], i == 0);
      check("mc_done", mdn[0], i == 3);
      check("mc_stall", {se[0], fm[0]}, (i < 3) ? 2'b11 : 2'b00);
      if (i < 3) check("mc_mask", {fd[0], fe[0]}, 2'b00);
      advance();
    end
    McOpE = 0;
    sample(); check("mc_cnt", scnt[0], 3); advance();

    do_reset();
    McOpE = 1;
    for (int i = 0; i < 8; i++) begin
      sample();
      check("b2b_start", mst[0], (i == 0) || (i == 4));
      check("b2b_done", mdn[0], (i == 3) || (i == 7));
      advance();
    end

    do_reset();
    McOpE = 1;
    sample(); advance();
    rst = 1;
    sample(); advance();
    rst = 0; McOpE = 0;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("rstb_busy", mbz[0], 0);
      check("rstb_done", mdn[0], 0);
      check("rstb_cnt", scnt[0], 0);
      advance();
    end

    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(0, 59) == 0);
      Rs1D       = 5'($urandom_range(0, 3));
      Rs2D       = 5'($urandom_range(0, 3));
      Rs1E       = 5'($urandom_range(0, 3));
      Rs2E       = 5'($urandom_range(0, 3));
      RdE        = 5'($urandom_range(0, 3));
      RdM        = 5'($urandom_range(0, 3));
      RdW        = 5'($urandom_range(0, 3));
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE     = ($urandom_range(0, 3) == 0);
      McOpE      = ($urandom_range(0, 2) == 0);
      sample();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
